// File: rtl/fft_bfly_if.sv
// Operand/result bus of the pipelined radix-2 butterfly: input handshake with
// A/B/W operands, output handshake with X/Y results, overflow flag and count.
interface fft_bfly_if #(
  parameter int DATA_W  = 16,
  parameter int COUNT_W = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  a_re;
  logic [DATA_W-1:0]  a_im;
  logic [DATA_W-1:0]  b_re;
  logic [DATA_W-1:0]  b_im;
  logic [DATA_W-1:0]  w_re;
  logic [DATA_W-1:0]  w_im;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  x_re;
  logic [DATA_W-1:0]  x_im;
  logic [DATA_W-1:0]  y_re;
  logic [DATA_W-1:0]  y_im;
  logic               ovf;
  logic [COUNT_W-1:0] bfly_count;

  modport master (
    output in_valid, a_re, a_im, b_re, b_im, w_re, w_im, out_ready,
    input  in_ready, out_valid, x_re, x_im, y_re, y_im, ovf, bfly_count
  );

  modport slave (
    input  in_valid, a_re, a_im, b_re, b_im, w_re, w_im, out_ready,
    output in_ready, out_valid, x_re, x_im, y_re, y_im, ovf, bfly_count
  );
endinterface

// File: rtl/fft_bfly_pipe.sv
// Three-stage pipelined radix-2 DIT butterfly: X/Y = (A +/- W*B) >>> SCALE with
// backpressure. Define FFT_BFLY_SAT_EN to clamp out-of-range results instead of wrapping.
module fft_bfly_pipe #(
  parameter int DATA_W  = 16,
  parameter int FRAC_W  = 15,
  parameter int SCALE   = 1,
  parameter int COUNT_W = 16
) (
  input  logic       clk,
  input  logic       reset,
  fft_bfly_if.slave  bus
);

  localparam int PW = 2 * DATA_W;   // full product width
  localparam int DW = PW + 1;       // product sum/difference width
  localparam int SW = DATA_W + 2;   // a +/- t width

  function automatic logic signed [SW-1:0] scale_shr(input logic signed [SW-1:0] v);
    return v >>> SCALE;
  endfunction

  // In range when every bit above the DATA_W sign position matches the sign.
  function automatic logic fits(input logic signed [SW-1:0] v);
    return v[SW-1:DATA_W-1] == {(SW - DATA_W + 1){v[SW-1]}};
  endfunction

  function automatic logic [DATA_W-1:0] reduce(input logic signed [SW-1:0] v);
`ifdef FFT_BFLY_SAT_EN
    if (!fits(v))
      return v[SW-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
`endif
    return v[DATA_W-1:0];
  endfunction

  logic vld_p1, vld_p2, vld_p3;
  logic adv_p1, adv_p2, adv_p3;
  logic take;

  // A stage moves forward when empty or when its successor moves.
  assign adv_p3       = !vld_p3 || bus.out_ready;
  assign adv_p2       = !vld_p2 || adv_p3;
  assign adv_p1       = !vld_p1 || adv_p2;
  assign bus.in_ready = adv_p1;
  assign take         = bus.in_valid && adv_p1;

  logic signed [PW-1:0] wr_x, wi_x, br_x, bi_x;

  assign wr_x = {{DATA_W{bus.w_re[DATA_W-1]}}, bus.w_re};
  assign wi_x = {{DATA_W{bus.w_im[DATA_W-1]}}, bus.w_im};
  assign br_x = {{DATA_W{bus.b_re[DATA_W-1]}}, bus.b_re};
  assign bi_x = {{DATA_W{bus.b_im[DATA_W-1]}}, bus.b_im};

  // ---- S1: partial products, A delayed ----
  logic signed [PW-1:0]     p_rr_p1, p_ii_p1, p_ri_p1, p_ir_p1;
  logic signed [DATA_W-1:0] a_re_p1, a_im_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      p_rr_p1 <= '0;
      p_ii_p1 <= '0;
      p_ri_p1 <= '0;
      p_ir_p1 <= '0;
      a_re_p1 <= '0;
      a_im_p1 <= '0;
    end else if (adv_p1) begin
      vld_p1 <= take;
      if (take) begin
        p_rr_p1 <= wr_x * br_x;
        p_ii_p1 <= wi_x * bi_x;
        p_ri_p1 <= wr_x * bi_x;
        p_ir_p1 <= wi_x * br_x;
        a_re_p1 <= bus.a_re;
        a_im_p1 <= bus.a_im;
      end
    end
  end

  logic signed [DW-1:0] d_re, d_im;
  logic signed [SW-1:0] t_re, t_im, a_re_x, a_im_x;

  assign d_re   = {p_rr_p1[PW-1], p_rr_p1} - {p_ii_p1[PW-1], p_ii_p1};
  assign d_im   = {p_ri_p1[PW-1], p_ri_p1} + {p_ir_p1[PW-1], p_ir_p1};
  // Floor shift back to DATA_W scale; |t| <= 2^DATA_W so SW bits always hold it.
  assign t_re   = SW'(d_re >>> FRAC_W);
  assign t_im   = SW'(d_im >>> FRAC_W);
  assign a_re_x = {{2{a_re_p1[DATA_W-1]}}, a_re_p1};
  assign a_im_x = {{2{a_im_p1[DATA_W-1]}}, a_im_p1};

  // ---- S2: twiddled B and unscaled butterfly sums ----
  logic signed [SW-1:0] x_re_p2, x_im_p2, y_re_p2, y_im_p2;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p2  <= 1'b0;
      x_re_p2 <= '0;
      x_im_p2 <= '0;
      y_re_p2 <= '0;
      y_im_p2 <= '0;
    end else if (adv_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        x_re_p2 <= a_re_x + t_re;
        x_im_p2 <= a_im_x + t_im;
        y_re_p2 <= a_re_x - t_re;
        y_im_p2 <= a_im_x - t_im;
      end
    end
  end

  logic signed [SW-1:0] sx_re, sx_im, sy_re, sy_im;
  logic                 ovf_n;

  assign sx_re = scale_shr(x_re_p2);
  assign sx_im = scale_shr(x_im_p2);
  assign sy_re = scale_shr(y_re_p2);
  assign sy_im = scale_shr(y_im_p2);
  assign ovf_n = !fits(sx_re) || !fits(sx_im) || !fits(sy_re) || !fits(sy_im);

  // ---- S3: scale, range reduction, output register ----
  logic [DATA_W-1:0]  x_re_p3, x_im_p3, y_re_p3, y_im_p3;
  logic               ovf_p3;
  logic [COUNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p3  <= 1'b0;
      x_re_p3 <= '0;
      x_im_p3 <= '0;
      y_re_p3 <= '0;
      y_im_p3 <= '0;
      ovf_p3  <= 1'b0;
    end else if (adv_p3) begin
      vld_p3 <= vld_p2;
      if (vld_p2) begin
        x_re_p3 <= reduce(sx_re);
        x_im_p3 <= reduce(sx_im);
        y_re_p3 <= reduce(sy_re);
        y_im_p3 <= reduce(sy_im);
        ovf_p3  <= ovf_n;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (vld_p3 && bus.out_ready)
      cnt <= cnt + COUNT_W'(1);
  end

  assign bus.out_valid  = vld_p3;
  assign bus.x_re       = x_re_p3;
  assign bus.x_im       = x_im_p3;
  assign bus.y_re       = y_re_p3;
  assign bus.y_im       = y_im_p3;
  assign bus.ovf        = ovf_p3;
  assign bus.bfly_count = cnt;

endmodule
